// File: rtl/locking_matrix_arbiter_pkg.sv
// Shared types and helpers for the locking matrix arbiter.
// Holds the arbiter state enum and the width helper used by the top and the matrix.
package locking_matrix_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << w) < value) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/locking_matrix_arbiter_prio_matrix.sv
// mx_prio_matrix: N x N priority matrix register, least-recently-granted update
// and combinational winner selection over the eligible vector.
module mx_prio_matrix
  import locking_matrix_arbiter_pkg::*;
#(
  parameter int N   = 5,
  parameter int IDW = clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   eligible_i,
  input  logic           upd_en_i,
  input  logic [IDW-1:0] upd_id_i,
  output logic [N-1:0]   winner_o,
  output logic [IDW-1:0] winner_id_o,
  output logic           any_o
);

  // prio_q[i][j] = 1 means channel i beats channel j.
  logic [N-1:0] prio_q [N];
  logic [N-1:0] prio_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) prio_d[i] = prio_q[i];
    if (upd_en_i) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (IDW'(i) == upd_id_i)      prio_d[i][j] = 1'b0;
          else if (IDW'(j) == upd_id_i) prio_d[i][j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) prio_q[i][j] <= (i < j);
      end
    end else begin
      prio_q <= prio_d;
    end
  end

  // The matrix is always a total order, so at most one eligible channel survives.
  always_comb begin
    winner_o    = '0;
    winner_id_o = '0;
    for (int i = 0; i < N; i++) begin
      winner_o[i] = eligible_i[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && eligible_i[j] && !prio_q[i][j]) winner_o[i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (winner_o[i]) winner_id_o = IDW'(i);
    end
  end

  assign any_o = |eligible_i;

endmodule

// File: rtl/locking_matrix_arbiter.sv
// Matrix arbiter with optional packet locking (enable with macro ARB_PACKET_LOCK_EN).
// Holds the FSM, lock counter and registered grant outputs.
module locking_matrix_arbiter
  import locking_matrix_arbiter_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int LOCK_LIMIT = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_CH-1:0]          requests,
  input  logic [N_CH-1:0]          enables,
  // Tail indication; "release" is a reserved word, hence the suffix.
  input  logic                     release_i,
  output logic [N_CH-1:0]          grants,
  output logic [clog2(N_CH)-1:0]   grant_id,
  output logic                     grant_valid,
  output logic                     locked,
  output arb_state_e               dbg_state_o
);

  localparam int ID_W = clog2(N_CH);

  arb_state_e        state_q, state_d;
  logic [N_CH-1:0]   grants_q, grants_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_CH-1:0]   eligible, winner;
  logic [ID_W-1:0]   winner_id;
  logic              any_elig, upd_en;

  assign eligible = requests & ~enables;

  mx_prio_matrix #(.N(N_CH), .IDW(ID_W)) u_matrix (
    .clk_i       (CLK),
    .rst_i       (RST),
    .eligible_i  (eligible),
    .upd_en_i    (upd_en),
    .upd_id_i    (winner_id),
    .winner_o    (winner),
    .winner_id_o (winner_id),
    .any_o       (any_elig)
  );

`ifdef ARB_PACKET_LOCK_EN
  localparam int CNT_W = clog2(LOCK_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_exit, arbitrate;

  always_comb begin
    state_d   = state_q;
    grants_d  = grants_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    upd_en    = 1'b0;
    lock_exit = (state_q == LOCKED) &&
                (release_i || !requests[id_q] ||
                 ((LOCK_LIMIT > 0) && (cnt_q == CNT_W'(LOCK_LIMIT - 1))));
    arbitrate = (state_q == IDLE) || lock_exit;
    if (state_q == LOCKED && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    // Exit and re-grant share one edge so back-to-back packets see no bubble.
    if (arbitrate) begin
      if (any_elig) begin
        state_d  = LOCKED;
        grants_d = winner;
        id_d     = winner_id;
        cnt_d    = '0;
        upd_en   = 1'b1;
      end else begin
        state_d  = IDLE;
        grants_d = '0;
        id_d     = '0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign locked = (state_q == LOCKED);
`else
  logic unused_release;
  localparam int unused_lock_limit = LOCK_LIMIT;
  assign unused_release = release_i;

  always_comb begin
    state_d  = IDLE;
    grants_d = winner;
    id_d     = winner_id;
    upd_en   = any_elig;
  end

  assign locked = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      grants_q <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      id_q     <= id_d;
    end
  end

  assign grants      = grants_q;
  assign grant_id    = id_q;
  assign grant_valid = |grants_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_locking_matrix_arbiter.sv
// Directed bench for locking_matrix_arbiter (N_CH=5); covers both builds of ARB_PACKET_LOCK_EN.
module tb_locking_matrix_arbiter;
  import locking_matrix_arbiter_pkg::*;

`ifdef ARB_PACKET_LOCK_EN
  localparam int LL      = 4;
  localparam bit LOCK_EN = 1'b1;
`else
  localparam int LL      = 0;
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] requests = '0;
  logic [4:0] enables = '0;
  logic       release_i = 1'b0;
  logic [4:0] grants;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       locked;
  arb_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  locking_matrix_arbiter #(.N_CH(5), .LOCK_LIMIT(LL)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .requests    (requests),
    .enables     (enables),
    .release_i   (release_i),
    .grants      (grants),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .locked      (locked),
    .dbg_state_o (dbg_state)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; requests = '0; enables = '0; release_i = 1'b0;
    step();
    RST = 1'b0;
  endtask

  function automatic logic [2:0] oh_idx(input logic [4:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic test_reset();
    RST = 1'b1; requests = 5'b11111; release_i = 1'b1;
    step();
    checks++;
    if (grants !== 5'b0 || grant_id !== 3'd0 || grant_valid !== 1'b0 ||
        locked !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset grants=%b id=%0d valid=%b locked=%b state=%0d expected 00000 0 0 0 0",
               grants, grant_id, grant_valid, locked, dbg_state);
    end
    RST = 1'b0; requests = '0; release_i = 1'b0;
  endtask

  // Release pulsed after the first grant: order 0,1,2,3,4,0 in both builds.
  task automatic test_round_robin();
    logic [4:0] exp_g;
    do_reset();
    requests = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      release_i = (k > 0);
      step();
      exp_g = 5'b00001 << (k % 5);
      checks++;
      if (grants !== exp_g || grant_id !== 3'(k % 5) || grant_valid !== 1'b1 || locked !== LOCK_EN) begin
        errors++;
        $display("FAIL round_robin[%0d] grants=%b id=%0d valid=%b locked=%b expected %b %0d 1 %b",
                 k, grants, grant_id, grant_valid, locked, exp_g, k % 5, LOCK_EN);
      end
    end
  endtask

  task automatic test_enables();
    logic [4:0] rq [3];
    logic [4:0] en [3];
    logic [4:0] eg [3];
    logic       el [3];
    rq = '{5'b00110, 5'b00110, 5'b00000};
    en = '{5'b00010, 5'b00010, 5'b00000};
    eg = '{5'b00100, 5'b00100, 5'b00000};
    el = '{LOCK_EN, LOCK_EN, 1'b0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      requests = rq[k]; enables = en[k];
      step();
      checks++;
      if (grants !== eg[k] || grant_id !== oh_idx(eg[k]) || grant_valid !== (|eg[k]) || locked !== el[k]) begin
        errors++;
        $display("FAIL enables[%0d] grants=%b id=%0d locked=%b expected %b %0d %b",
                 k, grants, grant_id, locked, eg[k], oh_idx(eg[k]), el[k]);
      end
    end
  endtask

  // Release held high: every cycle re-arbitrates, exercising matrix updates.
  task automatic test_matrix_order();
    logic [4:0] rq [6];
    logic [4:0] eg [6];
    rq = '{5'b11111, 5'b00011, 5'b00011, 5'b00011, 5'b10100, 5'b11000};
    eg = '{5'b00001, 5'b00010, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
    do_reset();
    release_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      requests = rq[k];
      step();
      checks++;
      if (grants !== eg[k] || grant_id !== oh_idx(eg[k]) || locked !== LOCK_EN) begin
        errors++;
        $display("FAIL matrix_order[%0d] grants=%b id=%0d locked=%b expected %b %0d %b",
                 k, grants, grant_id, locked, eg[k], oh_idx(eg[k]), LOCK_EN);
      end
    end
    release_i = 1'b0;
  endtask

  task automatic test_reset_restores_matrix();
    do_reset();
    release_i = 1'b1; requests = 5'b00001;
    step();
    checks++;
    if (grants !== 5'b00001 || locked !== LOCK_EN) begin
      errors++;
      $display("FAIL rst_restore_pre grants=%b locked=%b expected 00001 %b", grants, locked, LOCK_EN);
    end
    RST = 1'b1; requests = 5'b11111;
    step();
    checks++;
    if (grants !== 5'b0 || grant_id !== 3'd0 || grant_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_midlock grants=%b id=%0d valid=%b locked=%b expected 00000 0 0 0",
               grants, grant_id, grant_valid, locked);
    end
    RST = 1'b0; release_i = 1'b0; requests = 5'b00011;
    step();
    checks++;
    if (grants !== 5'b00001 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL rst_restore_post grants=%b id=%0d expected 00001 0", grants, grant_id);
    end
  endtask

  task automatic test_idle_release();
    do_reset();
    release_i = 1'b1; requests = '0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (grants !== 5'b0 || grant_valid !== 1'b0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL idle_release[%0d] grants=%b valid=%b locked=%b expected 00000 0 0",
                 k, grants, grant_valid, locked);
      end
    end
    release_i = 1'b0;
  endtask

`ifdef ARB_PACKET_LOCK_EN
  // Hold under busy flag, back-to-back on release, abandon, then idle.
  task automatic test_lock_hold();
    logic [4:0] rq [7];
    logic [4:0] en [7];
    logic       rl [7];
    logic [4:0] eg [7];
    logic       el [7];
    rq = '{5'b00110, 5'b00111, 5'b00111, 5'b00110, 5'b01010, 5'b00001, 5'b00000};
    en = '{5'b00010, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    rl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    eg = '{5'b00100, 5'b00100, 5'b00100, 5'b00010, 5'b01000, 5'b00001, 5'b00000};
    el = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      requests = rq[k]; enables = en[k]; release_i = rl[k];
      step();
      checks++;
      if (grants !== eg[k] || grant_id !== oh_idx(eg[k]) || locked !== el[k]) begin
        errors++;
        $display("FAIL lock_hold[%0d] grants=%b id=%0d locked=%b expected %b %0d %b",
                 k, grants, grant_id, locked, eg[k], oh_idx(eg[k]), el[k]);
      end
    end
    release_i = 1'b0; enables = '0;
  endtask

  task automatic test_lock_limit();
    logic [4:0] exp_g;
    do_reset();
    requests = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_g = (k < 4) ? 5'b00001 : 5'b00010;
      checks++;
      if (grants !== exp_g || locked !== 1'b1) begin
        errors++;
        $display("FAIL lock_limit[%0d] grants=%b locked=%b expected %b 1", k, grants, locked, exp_g);
      end
    end
  endtask
`else
  task automatic test_alternate();
    logic [4:0] exp_g;
    do_reset();
    requests = 5'b10001; release_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_g = (k % 2 == 0) ? 5'b00001 : 5'b10000;
      checks++;
      if (grants !== exp_g || grant_id !== oh_idx(exp_g) || locked !== 1'b0) begin
        errors++;
        $display("FAIL alternate[%0d] grants=%b id=%0d locked=%b expected %b %0d 0",
                 k, grants, grant_id, locked, exp_g, oh_idx(exp_g));
      end
    end
    release_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_enables();
    test_matrix_order();
    test_reset_restores_matrix();
    test_idle_release();
`ifdef ARB_PACKET_LOCK_EN
    test_lock_hold();
    test_lock_limit();
`else
    test_alternate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
